// File: rtl/serial_divider_p.sv
// serial_divider_p: byte-serial signed/unsigned integer divider, one quotient bit per cycle.
// Operands arrive MSB first; remainder then quotient leave LSB first under ready/valid.
`default_nettype none

module serial_divider_p #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_sign,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       out_last,
  output logic       div_by_zero,
  output logic       overflow,
  output logic       busy
);

  localparam int BYTES = WIDTH / 8;
  localparam int NB    = 2 * BYTES;
  localparam int CW    = $clog2(NB);
  localparam int IW    = $clog2(WIDTH + 1);
  localparam int LW    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FIX, S_SEND} state_t;

  state_t               r_state, w_next;
  logic                 r_sign;
  logic [2*WIDTH-1:0]   r_opnd;
  logic [CW-1:0]        r_in_cnt, r_out_cnt;
  logic [IW-1:0]        r_iter;
  logic [WIDTH-1:0]     r_rem, r_quo;
  logic [2*WIDTH-1:0]   r_res;
  logic                 r_dbz, r_ovf;

  logic [WIDTH-1:0] w_dvd, w_dvs, w_a_mag, w_b_mag, w_q_fix, w_r_fix;
  logic [WIDTH:0]   w_shift, w_diff;
  logic [LW-1:0]    w_idx;
  logic             w_ge, w_accept, w_xfer, w_in_last, w_qneg, w_rneg, w_dbz, w_ovf;

  assign in_ready    = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign out_valid   = (r_state == S_SEND);
  assign out_last    = out_valid && (r_out_cnt == CW'(NB - 1));
  assign out_data    = r_res[7:0];
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;
  assign busy        = (r_state != S_IDLE);

  assign w_accept  = in_valid & in_ready;
  assign w_xfer    = out_valid & out_ready;
  assign w_in_last = w_accept && (r_in_cnt == CW'(NB - 1));

  // Operands stay in r_opnd untouched through CALC/FIX; magnitudes are derived on the fly.
  assign w_dvd   = r_opnd[2*WIDTH-1:WIDTH];
  assign w_dvs   = r_opnd[WIDTH-1:0];
  assign w_a_mag = (r_sign & w_dvd[WIDTH-1]) ? -w_dvd : w_dvd;
  assign w_b_mag = (r_sign & w_dvs[WIDTH-1]) ? -w_dvs : w_dvs;
  assign w_qneg  = r_sign & (w_dvd[WIDTH-1] ^ w_dvs[WIDTH-1]);
  assign w_rneg  = r_sign & w_dvd[WIDTH-1];

  // Restoring step; the borrow bit of the WIDTH+1-bit difference decides the quotient bit.
  assign w_idx   = LW'(r_iter - IW'(1));
  assign w_shift = {r_rem, w_a_mag[w_idx]};
  assign w_diff  = w_shift - {1'b0, w_b_mag};
  assign w_ge    = ~w_diff[WIDTH];

  always_comb begin
    w_dbz   = (w_dvs == '0);
    w_ovf   = r_sign && (w_dvd == C_MIN) && (w_dvs == '1);
    w_q_fix = w_qneg ? -r_quo : r_quo;
    w_r_fix = w_rneg ? -r_rem : r_rem;
    if (w_dbz) begin
      w_q_fix = '1;
      w_r_fix = w_dvd;
    end else if (w_ovf) begin
      w_q_fix = w_dvd;
      w_r_fix = '0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_LOAD;
      S_LOAD:  if (w_in_last) w_next = S_CALC;
      S_CALC:  if (r_iter == IW'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_SEND;
      S_SEND:  if (w_xfer && out_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign    <= 1'b0;
      r_opnd    <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_iter    <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_res     <= '0;
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opnd   <= {r_opnd[2*WIDTH-9:0], in_data};
        r_in_cnt <= w_in_last ? '0 : r_in_cnt + CW'(1);
        if (r_state == S_IDLE) r_sign <= in_sign;
      end
      if (w_in_last) begin
        r_iter <= IW'(WIDTH);
        r_rem  <= '0;
        r_quo  <= '0;
      end
      if (r_state == S_CALC) begin
        r_iter <= r_iter - IW'(1);
        r_rem  <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_quo  <= {r_quo[WIDTH-2:0], w_ge};
      end
      if (r_state == S_FIX) begin
        r_res <= {w_q_fix, w_r_fix};
        r_dbz <= w_dbz;
        r_ovf <= w_ovf;
      end
      if (w_xfer) begin
        r_res <= {8'h00, r_res[2*WIDTH-1:8]};
        if (out_last) begin
          r_out_cnt <= '0;
          r_dbz     <= 1'b0;
          r_ovf     <= 1'b0;
        end else begin
          r_out_cnt <= r_out_cnt + CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_divider_p.sv
// Randomized self-checking bench for serial_divider_p against a plain-arithmetic reference.
`default_nettype none

module tb_serial_divider_p;
  localparam int W  = 32;
  localparam int NB = 2 * (W / 8);
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_sign, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_last, div_by_zero, overflow, busy;
  logic [7:0] out_data;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  serial_divider_p #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_sign(in_sign), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_last(out_last),
    .div_by_zero(div_by_zero), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns {div_by_zero, overflow, quotient, remainder}.
  function automatic logic [2*W+1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn);
    logic [W-1:0] q, r;
    logic signed [W-1:0] sa, sb;
    logic dz, ov;
    sa = a; sb = b; dz = 1'b0; ov = 1'b0;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (sgn && a == MINV && b == '1) begin
      q = a; r = '0; ov = 1'b1;
    end else if (sgn) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return {dz, ov, q, r};
  endfunction

  task automatic send_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input bit gaps, output int e);
    logic [2*W-1:0] s;
    s = {a, b};
    for (int i = 0; i < NB; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = s[2*W-1-8*i -: 8];
      in_sign  = (i == 0) ? sgn : 1'($urandom_range(0, 1));
      check_val("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    e = cyc;
    check_val("busy_after_load", busy, 1);
    check_val("in_ready_calc", in_ready, 0);
  endtask

  task automatic recv_ops(input logic [2*W+1:0] exp, input int e, input bit stall, input bit noise);
    logic [2*W-1:0] res;
    logic [7:0]     prev;
    bit             stalled, rdy;
    int             guard, idx;
    res = exp[2*W-1:0];
    guard = 0;
    while (!out_valid && guard < W + 10) begin
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = 8'($urandom);
      check_val("in_ready_wait", in_ready, 0);
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    check_val("out_valid_timeout", out_valid, 1);
    if (!out_valid) return;
    check_val("latency", cyc, e + W + 1);
    idx = 0; stalled = 0; prev = '0; guard = 0;
    while (idx < NB && guard < 20 * NB) begin
      check_val("out_valid", out_valid, 1);
      if (stalled) check_val("stable", out_data, prev);
      check_val($sformatf("byte%0d", idx), out_data, res[8*idx +: 8]);
      check_val("out_last", out_last, (idx == NB - 1));
      check_val("div_by_zero", div_by_zero, exp[2*W+1]);
      check_val("overflow", overflow, exp[2*W]);
      rdy = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      out_ready = rdy;
      in_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 8'($urandom);
      prev      = out_data;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (rdy) begin idx++; stalled = 0; end
      else stalled = 1;
      guard++;
    end
    out_ready = 1'b0;
    check_val("send_done", idx, NB);
    check_val("idle_valid", out_valid, 0);
    check_val("idle_busy", busy, 0);
    check_val("idle_in_ready", in_ready, 1);
    check_val("idle_dbz", div_by_zero, 0);
    check_val("idle_ovf", overflow, 0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input bit gaps, input bit stall, input bit noise);
    int e;
    send_ops(a, b, sgn, gaps, e);
    recv_ops(ref_div(a, b, sgn), e, stall, noise);
  endtask

  initial begin
    int e;
    bit saw;
    logic [W-1:0] a, b;
    logic sg;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sign = 1'b0; out_ready = 1'b0;
    #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_dbz", div_by_zero, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0, 0, 0, 0);
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 0, 0, 0);
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, 0, 0, 0);
    run_op(32'h12345678, 32'd0, 1'b0, 0, 0, 0);
    run_op(32'h87654321, 32'd0, 1'b1, 0, 0, 0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0, 0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0, 0);
    run_op(32'd100, 32'd7, 1'b0, 1, 1, 1);
    run_op(32'hFFFFFF9C, 32'd7, 1'b1, 0, 0, 0);

    // Abort in the middle of CALC; nothing may come out afterwards.
    send_ops(32'hDEADBEEF, 32'd3, 1'b0, 0, e);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_in_ready", in_ready, 1);
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_out_data", out_data, 0);
    @(negedge clk) rst = 1'b0;
    saw = 0;
    repeat (W + 8) begin
      @(posedge clk); #1;
      if (out_valid || busy) saw = 1;
    end
    check_val("no_out_after_rst", saw, 0);
    run_op(32'd100, 32'd7, 1'b0, 0, 0, 0);

    for (int k = 0; k < 30; k++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = MINV; b = '1; end
        2: b = (a == 0) ? 32'd1 : a;
        default: ;
      endcase
      run_op(a, b, sg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected <2000000 ns", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
